// File: rtl/icache_pkg.sv
// Shared constants, FSM encoding and PC field helpers for the instruction cache.
package icache_pkg;

   localparam int unsigned LINE_BYTES = 64;
   localparam int unsigned OFFSET_W   = 6;
   localparam int unsigned WORD_SEL_W = 4;
   localparam int unsigned LINE_BITS  = LINE_BYTES * 8;

   typedef enum logic [1:0] {
      StIdle,
      StLookup,
      StMiss,
      StResp
   } state_e;

   function automatic logic [WORD_SEL_W-1:0] pc_word(input logic [31:0] pc);
      return pc[OFFSET_W-1:2];
   endfunction

   // Index and tag are returned zero-extended; callers cut them to IDX_W / TAG_W.
   function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned idx_w);
      return (pc >> OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned idx_w);
      return pc >> (OFFSET_W + idx_w);
   endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and mem_ctrl-side signals of the instruction cache.
interface icache_if;
   import icache_pkg::*;

   logic                 if_req;
   logic [31:0]          if_pc;
   logic                 if_ready;
   logic                 if_valid;
   logic [31:0]          if_inst;
   logic [31:0]          if_pc_out;
   logic                 mem_req;
   logic [31:0]          mem_pc;
   logic [LINE_BITS-1:0] mem_row;
   logic                 mem_row_valid;

   // master: fetch stage plus mem_ctrl; slave: the cache
   modport master (
      output if_req, if_pc, mem_row, mem_row_valid,
      input  if_ready, if_valid, if_inst, if_pc_out, mem_req, mem_pc
   );

   modport slave (
      input  if_req, if_pc, mem_row, mem_row_valid,
      output if_ready, if_valid, if_inst, if_pc_out, mem_req, mem_pc
   );

endinterface

// File: rtl/icache_tag_array.sv
// Valid bits and tags for the direct-mapped cache; valid bits clear on reset.
module icache_tag_array #(
   parameter int unsigned LINE_NUM = 16,
   parameter int unsigned IDX_W    = 4,
   parameter int unsigned TAG_W    = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag
);

   logic [LINE_NUM-1:0] valid_q;
   logic [TAG_W-1:0]    tag_q [LINE_NUM];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx] <= wr_tag;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: 64-byte lines, one outstanding line fill towards mem_ctrl.
module icache
   import icache_pkg::*;
#(
   parameter int unsigned LINE_NUM = 16
) (
   input logic     clk,
   input logic     rst,
   input logic     rdy,
   input logic     rollback,
   icache_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(LINE_NUM);
   localparam int unsigned TAG_W = 26 - IDX_W;

   state_e      state_q, state_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [31:0] fill_pc_q, fill_pc_d;
   logic        fill_pending_q, fill_pending_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic [31:0] if_pc_out_q, if_pc_out_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_pc_q, mem_pc_d;

   logic [LINE_BITS-1:0] data_q [LINE_NUM];

   logic [31:0]          lookup_pc;
   logic [IDX_W-1:0]     rd_idx, fill_idx;
   logic [TAG_W-1:0]     rd_tag, lk_tag, fill_tag;
   logic                 rd_valid, hit, fill_we;
   logic [LINE_BITS-1:0] rd_line;
   logic [31:0]          rd_word, fill_word;

   // Probing with the incoming PC while idle lets a hit answer one cycle after accept.
   assign lookup_pc = (state_q == StIdle) ? bus.if_pc : req_pc_q;
   assign rd_idx    = IDX_W'(pc_index(lookup_pc, IDX_W));
   assign lk_tag    = TAG_W'(pc_tag(lookup_pc, IDX_W));
   assign fill_idx  = IDX_W'(pc_index(fill_pc_q, IDX_W));
   assign fill_tag  = TAG_W'(pc_tag(fill_pc_q, IDX_W));
   assign hit       = rd_valid && (rd_tag == lk_tag);
   assign rd_line   = data_q[rd_idx];
   assign rd_word   = rd_line[{pc_word(lookup_pc), 5'd0} +: 32];
   assign fill_word = bus.mem_row[{pc_word(fill_pc_q), 5'd0} +: 32];
   // Every row that arrives while a fill is outstanding is installed, orphaned or not.
   assign fill_we   = rdy && bus.mem_row_valid && fill_pending_q;

   icache_tag_array #(
      .LINE_NUM(LINE_NUM),
      .IDX_W   (IDX_W),
      .TAG_W   (TAG_W)
   ) u_tags (
      .clk     (clk),
      .rst     (rst),
      .rd_idx  (rd_idx),
      .rd_valid(rd_valid),
      .rd_tag  (rd_tag),
      .wr_en   (fill_we),
      .wr_idx  (fill_idx),
      .wr_tag  (fill_tag)
   );

   always_comb begin
      state_d        = state_q;
      req_pc_d       = req_pc_q;
      fill_pc_d      = fill_pc_q;
      fill_pending_d = fill_pending_q && !fill_we;
      if_valid_d     = 1'b0;
      if_inst_d      = if_inst_q;
      if_pc_out_d    = if_pc_out_q;
      mem_req_d      = mem_req_q;
      mem_pc_d       = mem_pc_q;
      if (rollback) begin
         state_d   = StIdle;
         mem_req_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.if_req) begin
                  state_d  = StLookup;
                  req_pc_d = bus.if_pc;
                  if (hit) begin
                     if_valid_d  = 1'b1;
                     if_inst_d   = rd_word;
                     if_pc_out_d = bus.if_pc;
                  end
               end
            end
            StLookup: begin
               if (if_valid_q) begin
                  state_d = StIdle;
               end else if (hit) begin
                  state_d     = StIdle;
                  if_valid_d  = 1'b1;
                  if_inst_d   = rd_word;
                  if_pc_out_d = req_pc_q;
               end else if (!fill_pending_q) begin
                  state_d        = StMiss;
                  fill_pending_d = 1'b1;
                  fill_pc_d      = req_pc_q;
                  mem_req_d      = 1'b1;
                  mem_pc_d       = req_pc_q;
               end
               // Otherwise wait: the orphan fill may bring in this very line.
            end
            StMiss: begin
               if (bus.mem_row_valid) begin
                  state_d     = StResp;
                  mem_req_d   = 1'b0;
                  if_valid_d  = 1'b1;
                  if_inst_d   = fill_word;
                  if_pc_out_d = fill_pc_q;
               end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= StIdle;
         req_pc_q       <= '0;
         fill_pc_q      <= '0;
         fill_pending_q <= 1'b0;
         if_valid_q     <= 1'b0;
         if_inst_q      <= '0;
         if_pc_out_q    <= '0;
         mem_req_q      <= 1'b0;
         mem_pc_q       <= '0;
      end else if (rdy) begin
         state_q        <= state_d;
         req_pc_q       <= req_pc_d;
         fill_pc_q      <= fill_pc_d;
         fill_pending_q <= fill_pending_d;
         if_valid_q     <= if_valid_d;
         if_inst_q      <= if_inst_d;
         if_pc_out_q    <= if_pc_out_d;
         mem_req_q      <= mem_req_d;
         mem_pc_q       <= mem_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_we) begin
         data_q[fill_idx] <= bus.mem_row;
      end
   end

   // A pending pulse is held back while frozen and dropped when its request is rolled back.
   assign bus.if_valid  = if_valid_q && rdy && !rollback;
   assign bus.if_ready  = (state_q == StIdle);
   assign bus.if_inst   = if_inst_q;
   assign bus.if_pc_out = if_pc_out_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_pc    = mem_pc_q;

endmodule
